rf_wb_arb: RTL and testbench

Write-back arbiter and scoreboard for the ONC-16 register file. Two producers, the ALU (requester A) and the load/store unit (requester B), share the file's single synchronous write port. The block grants one of them per cycle, registers the winning write onto the port, and tracks in-flight destination registers. It gives decode a combinational stall signal for read-after-write and write-after-write hazards. It sits between the execute/memory stages and `reg_file`, and drives `we`, `w_addr` and `w_data` directly.

---
 rtl/rf_wb_arb_if.sv | 48 ++++
 rtl/rf_wb_arb.sv | 116 +++++++++++
 tb/tb_rf_wb_arb.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_wb_arb_if.sv
// Bus bundle between execute/memory producers, decode and rf_wb_arb: write requests,
// scoreboard issue/query, bypass outputs and the registered register-file write port.
interface rf_wb_arb_if #(
    parameter int DATA_W    = 16,
    parameter int RF_ADDR_W = 4,
    parameter int RF_REG    = 16
);
    logic                 a_valid;
    logic                 a_ready;
    logic [RF_ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0]    a_data;

    logic                 b_valid;
    logic                 b_ready;
    logic [RF_ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0]    b_data;

    logic                 iss_valid;
    logic [RF_ADDR_W-1:0] iss_addr;
    logic [RF_ADDR_W-1:0] q1_addr;
    logic [RF_ADDR_W-1:0] q2_addr;
    logic [RF_ADDR_W-1:0] q_dst;
    logic                 q_stall;
    logic                 fwd1_hit;
    logic                 fwd2_hit;
    logic [DATA_W-1:0]    fwd_data;

    logic                 we;
    logic [RF_ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0]    w_data;
    logic [RF_REG-1:0]    busy;

    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        output iss_valid, iss_addr, q1_addr, q2_addr, q_dst,
        input  a_ready, b_ready, q_stall, fwd1_hit, fwd2_hit, fwd_data,
        input  we, w_addr, w_data, busy
    );

    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        input  iss_valid, iss_addr, q1_addr, q2_addr, q_dst,
        output a_ready, b_ready, q_stall, fwd1_hit, fwd2_hit, fwd_data,
        output we, w_addr, w_data, busy
    );
endinterface

// File: rtl/rf_wb_arb.sv
// rf_wb_arb: write-back arbiter (LSU priority, ALU anti-starvation) and busy scoreboard for ONC-16.
// Widths mirror def.v (DATA_W, RF_ADDR_W, RF_REG, RF_ZERO); macro RF_WB_BYPASS_EN enables bypass.
module rf_wb_arb #(
    parameter int STARVE_MAX = 3,
    parameter int DATA_W     = 16,
    parameter int RF_ADDR_W  = 4,
    parameter int RF_REG     = 16,
    parameter int RF_ZERO    = 0
) (
    input  logic       clock,
    input  logic       n_rst,
    rf_wb_arb_if.slave bus
);
    localparam int                   CNT_W      = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]     STARVE_LIM = CNT_W'(STARVE_MAX);
    localparam logic [RF_ADDR_W-1:0] ZERO_ADDR  = RF_ADDR_W'(RF_ZERO);

    logic [CNT_W-1:0]     r_wait_cnt;
    logic                 r_we;
    logic [RF_ADDR_W-1:0] r_w_addr;
    logic [DATA_W-1:0]    r_w_data;
    logic [RF_REG-1:0]    r_busy;

    logic                 w_grant_a;
    logic                 w_a_hs;
    logic                 w_b_hs;
    logic                 w_hs;
    logic [RF_ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0]    w_win_data;
    logic [RF_REG-1:0]    w_busy_nxt;
    logic                 w_q1_busy;
    logic                 w_q2_busy;
    logic                 w_qd_busy;
    logic                 w_fwd1;
    logic                 w_fwd2;

    // Ready depends only on valids and the wait counter, never on the readies.
    assign w_grant_a  = bus.a_valid & (~bus.b_valid | (r_wait_cnt >= STARVE_LIM));
    assign w_a_hs     = w_grant_a;
    assign w_b_hs     = bus.b_valid & ~w_grant_a;
    assign w_hs       = w_a_hs | w_b_hs;
    assign w_win_addr = w_a_hs ? bus.a_addr : bus.b_addr;
    assign w_win_data = w_a_hs ? bus.a_data : bus.b_data;

    assign bus.a_ready = w_a_hs;
    assign bus.b_ready = w_b_hs;

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            r_wait_cnt <= '0;
        end else if (w_a_hs) begin
            r_wait_cnt <= '0;
        end else if (bus.a_valid && (r_wait_cnt < STARVE_LIM)) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
    end

    // A handshake to the zero register still loads addr/data but never raises we.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            r_we     <= 1'b0;
            r_w_addr <= '0;
            r_w_data <= '0;
        end else begin
            r_we <= w_hs & (w_win_addr != ZERO_ADDR);
            if (w_hs) begin
                r_w_addr <= w_win_addr;
                r_w_data <= w_win_data;
            end
        end
    end

    // Clear is applied before set so an issue in the same cycle keeps the bit busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_we) begin
            w_busy_nxt[r_w_addr] = 1'b0;
        end
        if (bus.iss_valid && (bus.iss_addr != ZERO_ADDR)) begin
            w_busy_nxt[bus.iss_addr] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign w_q1_busy = r_busy[bus.q1_addr] & (bus.q1_addr != ZERO_ADDR);
    assign w_q2_busy = r_busy[bus.q2_addr] & (bus.q2_addr != ZERO_ADDR);
    assign w_qd_busy = r_busy[bus.q_dst]   & (bus.q_dst   != ZERO_ADDR);

`ifdef RF_WB_BYPASS_EN
    // Sources may take the in-progress write value; the WAW destination check never bypasses.
    assign w_fwd1       = r_we & (r_w_addr == bus.q1_addr) & (bus.q1_addr != ZERO_ADDR);
    assign w_fwd2       = r_we & (r_w_addr == bus.q2_addr) & (bus.q2_addr != ZERO_ADDR);
    assign bus.fwd_data = r_w_data;
    assign bus.q_stall  = (w_q1_busy & ~w_fwd1) | (w_q2_busy & ~w_fwd2) | w_qd_busy;
`else
    assign w_fwd1       = 1'b0;
    assign w_fwd2       = 1'b0;
    assign bus.fwd_data = '0;
    assign bus.q_stall  = w_q1_busy | w_q2_busy | w_qd_busy;
`endif

    assign bus.fwd1_hit = w_fwd1;
    assign bus.fwd2_hit = w_fwd2;

    assign bus.we     = r_we;
    assign bus.w_addr = r_w_addr;
    assign bus.w_data = r_w_data;
    assign bus.busy   = r_busy;
endmodule

// File: tb/tb_rf_wb_arb.sv
// tb_rf_wb_arb: directed vector table, reset-during-write sequence and a random run
// compared against a behavioural model of arbitration, write port and scoreboard.
`timescale 1ns/1ps
module tb_rf_wb_arb;
    localparam int STARVE_MAX = 3;
    localparam int DATA_W     = 16;
    localparam int RF_ADDR_W  = 4;
    localparam int RF_REG     = 16;
    localparam int N_VEC      = 17;
    localparam int N_RAND     = 3000;
`ifdef RF_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clock = 1'b0;
    logic n_rst = 1'b0;
    always #5 clock = ~clock;

    rf_wb_arb_if #(.DATA_W(DATA_W), .RF_ADDR_W(RF_ADDR_W), .RF_REG(RF_REG)) bus ();

    rf_wb_arb #(
        .STARVE_MAX(STARVE_MAX),
        .DATA_W    (DATA_W),
        .RF_ADDR_W (RF_ADDR_W),
        .RF_REG    (RF_REG),
        .RF_ZERO   (0)
    ) dut (
        .clock(clock),
        .n_rst(n_rst),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        av;
        logic [3:0]  aa;
        logic [15:0] ad;
        logic        bv;
        logic [3:0]  ba;
        logic [15:0] bd;
        logic        iv;
        logic [3:0]  ia;
        logic [3:0]  q1;
        logic [3:0]  q2;
        logic [3:0]  qd;
        logic        ear;
        logic        ebr;
        logic        ewe;
        logic [3:0]  ewa;
        logic [15:0] ewd;
        logic [15:0] ebusy;
        logic        estall;
    } vec_t;

    vec_t tbl [N_VEC];

    function automatic vec_t mk(int av, int aa, int ad, int bv, int ba, int bd, int iv, int ia,
                                int q1, int q2, int qd, int ear, int ebr, int ewe, int ewa,
                                int ewd, int ebusy, int estall);
        vec_t v;
        v.av = 1'(av);  v.aa = 4'(aa);  v.ad = 16'(ad);
        v.bv = 1'(bv);  v.ba = 4'(ba);  v.bd = 16'(bd);
        v.iv = 1'(iv);  v.ia = 4'(ia);
        v.q1 = 4'(q1);  v.q2 = 4'(q2);  v.qd = 4'(qd);
        v.ear = 1'(ear); v.ebr = 1'(ebr); v.ewe = 1'(ewe);
        v.ewa = 4'(ewa); v.ewd = 16'(ewd); v.ebusy = 16'(ebusy); v.estall = 1'(estall);
        return v;
    endfunction

    task automatic drive(input logic av, input logic [3:0] aa, input logic [15:0] ad,
                         input logic bv, input logic [3:0] ba, input logic [15:0] bd,
                         input logic iv, input logic [3:0] ia,
                         input logic [3:0] q1, input logic [3:0] q2, input logic [3:0] qd);
        bus.a_valid = av;  bus.a_addr = aa;  bus.a_data = ad;
        bus.b_valid = bv;  bus.b_addr = ba;  bus.b_data = bd;
        bus.iss_valid = iv; bus.iss_addr = ia;
        bus.q1_addr = q1;  bus.q2_addr = q2; bus.q_dst = qd;
    endtask

    // Reference model: pending write, busy set, and how long A has been refused in a row.
    bit          m_busy [RF_REG];
    bit          m_we;
    logic [3:0]  m_wa;
    logic [15:0] m_wd;
    int          m_refused;

    task automatic model_reset();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_we = 1'b0; m_wa = '0; m_wd = '0; m_refused = 0;
    endtask

    function automatic logic [15:0] model_busy_vec();
        logic [15:0] v;
        for (int i = 0; i < RF_REG; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic bit src_stall(logic [3:0] q);
        return (q != 0) && m_busy[q] && !(BYP && m_we && (m_wa == q));
    endfunction

    function automatic bit model_stall(logic [3:0] q1, logic [3:0] q2, logic [3:0] qd);
        return src_stall(q1) || src_stall(q2) || ((qd != 0) && m_busy[qd]);
    endfunction

    function automatic bit model_grant_a(logic av, logic bv);
        return av && (!bv || (m_refused >= STARVE_MAX));
    endfunction

    task automatic model_step();
        bit ga, gb;
        ga = model_grant_a(bus.a_valid, bus.b_valid);
        gb = bus.b_valid && !ga;
        if (m_we) m_busy[m_wa] = 1'b0;
        if (bus.iss_valid && (bus.iss_addr != 0)) m_busy[bus.iss_addr] = 1'b1;
        if (ga || gb) begin
            m_wa = ga ? bus.a_addr : bus.b_addr;
            m_wd = ga ? bus.a_data : bus.b_data;
            m_we = (m_wa != 0);
        end else begin
            m_we = 1'b0;
        end
        if (ga) m_refused = 0;
        else if (bus.a_valid && m_refused < STARVE_MAX) m_refused++;
    endtask

    initial begin
        bit       stall;
        bit       ga;
        bit       iv;
        bit       f1, f2;
        logic [3:0] ia, q1, q2, qd;

        // av aa ad | bv ba bd | iv ia | q1 q2 qd | ear ebr ewe ewa ewd busy stall
        tbl[0]  = mk(1, 1, 'hA001, 1, 2, 'hB001, 0, 0, 0, 0, 0, 0, 1, 0, 0, 'h0000, 'h0000, 0);
        tbl[1]  = mk(1, 1, 'hA001, 1, 3, 'hB002, 0, 0, 0, 0, 0, 0, 1, 1, 2, 'hB001, 'h0000, 0);
        tbl[2]  = mk(1, 1, 'hA001, 1, 4, 'hB003, 0, 0, 0, 0, 0, 0, 1, 1, 3, 'hB002, 'h0000, 0);
        tbl[3]  = mk(1, 1, 'hA001, 1, 5, 'hB004, 0, 0, 0, 0, 0, 1, 0, 1, 4, 'hB003, 'h0000, 0);
        tbl[4]  = mk(0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0, 0, 0, 1, 1, 'hA001, 'h0000, 0);
        tbl[5]  = mk(1, 0, 'h1234, 0, 0, 0,      0, 0, 0, 0, 0, 1, 0, 0, 1, 'hA001, 'h0000, 0);
        tbl[6]  = mk(0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0, 0, 0, 0, 0, 'h1234, 'h0000, 0);
        tbl[7]  = mk(0, 0, 0,      0, 0, 0,      1, 3, 0, 0, 0, 0, 0, 0, 0, 'h1234, 'h0000, 0);
        tbl[8]  = mk(0, 0, 0,      0, 0, 0,      0, 0, 0, 3, 0, 0, 0, 0, 0, 'h1234, 'h0008, 1);
        tbl[9]  = mk(0, 0, 0,      1, 3, 'h00AA, 0, 0, 3, 0, 0, 0, 1, 0, 0, 'h1234, 'h0008, 1);
        tbl[10] = mk(0, 0, 0,      0, 0, 0,      0, 0, 3, 0, 0, 0, 0, 1, 3, 'h00AA, 'h0008, BYP ? 0 : 1);
        tbl[11] = mk(0, 0, 0,      0, 0, 0,      1, 0, 3, 0, 0, 0, 0, 0, 3, 'h00AA, 'h0000, 0);
        tbl[12] = mk(1, 5, 'h5555, 0, 0, 0,      0, 0, 0, 0, 0, 1, 0, 0, 3, 'h00AA, 'h0000, 0);
        tbl[13] = mk(0, 0, 0,      0, 0, 0,      1, 5, 0, 0, 0, 0, 0, 1, 5, 'h5555, 'h0000, 0);
        tbl[14] = mk(0, 0, 0,      1, 5, 'h0555, 0, 0, 0, 0, 5, 0, 1, 0, 5, 'h5555, 'h0020, 1);
        tbl[15] = mk(0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 5, 0, 0, 1, 5, 'h0555, 'h0020, 1);
        tbl[16] = mk(0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 5, 0, 0, 0, 5, 'h0555, 'h0000, 0);

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clock);
        #1;
        chk("rst we",      32'(bus.we),      32'd0);
        chk("rst w_addr",  32'(bus.w_addr),  32'd0);
        chk("rst w_data",  32'(bus.w_data),  32'd0);
        chk("rst busy",    32'(bus.busy),    32'd0);
        chk("rst q_stall", 32'(bus.q_stall), 32'd0);
        @(negedge clock);
        n_rst = 1'b1;

        for (int i = 0; i < N_VEC; i++) begin
            @(negedge clock);
            drive(tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].bv, tbl[i].ba, tbl[i].bd,
                  tbl[i].iv, tbl[i].ia, tbl[i].q1, tbl[i].q2, tbl[i].qd);
            #1;
            f1 = BYP && tbl[i].ewe && (tbl[i].ewa == tbl[i].q1) && (tbl[i].q1 != 0);
            f2 = BYP && tbl[i].ewe && (tbl[i].ewa == tbl[i].q2) && (tbl[i].q2 != 0);
            chk($sformatf("vec%0d a_ready", i),  32'(bus.a_ready),  32'(tbl[i].ear));
            chk($sformatf("vec%0d b_ready", i),  32'(bus.b_ready),  32'(tbl[i].ebr));
            chk($sformatf("vec%0d we", i),       32'(bus.we),       32'(tbl[i].ewe));
            chk($sformatf("vec%0d w_addr", i),   32'(bus.w_addr),   32'(tbl[i].ewa));
            chk($sformatf("vec%0d w_data", i),   32'(bus.w_data),   32'(tbl[i].ewd));
            chk($sformatf("vec%0d busy", i),     32'(bus.busy),     32'(tbl[i].ebusy));
            chk($sformatf("vec%0d q_stall", i),  32'(bus.q_stall),  32'(tbl[i].estall));
            chk($sformatf("vec%0d fwd1", i),     32'(bus.fwd1_hit), 32'(f1));
            chk($sformatf("vec%0d fwd2", i),     32'(bus.fwd2_hit), 32'(f2));
            chk($sformatf("vec%0d fwd_data", i), 32'(bus.fwd_data), BYP ? 32'(tbl[i].ewd) : 32'd0);
        end

        // Reset asserted while a granted write is on the port.
        @(negedge clock);
        drive(0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0);
        @(negedge clock);
        drive(0, 0, 0, 1, 7, 'h7777, 0, 0, 7, 0, 0);
        #1;
        chk("rstseq b_ready", 32'(bus.b_ready), 32'd1);
        chk("rstseq busy",    32'(bus.busy),    32'h0080);
        @(posedge clock);
        #1;
        chk("rstseq we pre",  32'(bus.we),      32'd1);
        n_rst = 1'b0;
        #1;
        chk("rstseq we",       32'(bus.we),       32'd0);
        chk("rstseq busy0",    32'(bus.busy),     32'd0);
        chk("rstseq w_addr",   32'(bus.w_addr),   32'd0);
        chk("rstseq w_data",   32'(bus.w_data),   32'd0);
        chk("rstseq q_stall",  32'(bus.q_stall),  32'd0);
        chk("rstseq fwd1",     32'(bus.fwd1_hit), 32'd0);
        chk("rstseq fwd_data", 32'(bus.fwd_data), 32'd0);
        @(negedge clock);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0);
        n_rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clock);
            #1;
            chk($sformatf("rstseq post%0d we", i),   32'(bus.we),      32'd0);
            chk($sformatf("rstseq post%0d busy", i), 32'(bus.busy),    32'd0);
            chk($sformatf("rstseq post%0d stall", i), 32'(bus.q_stall), 32'd0);
        end

        // Random traffic from a fresh reset against the model.
        @(negedge clock);
        n_rst = 1'b0;
        @(negedge clock);
        n_rst = 1'b1;
        model_reset();
        for (int c = 0; c < N_RAND; c++) begin
            @(negedge clock);
            q1 = 4'($urandom_range(0, 15));
            q2 = 4'($urandom_range(0, 15));
            qd = 4'($urandom_range(0, 15));
            ia = 4'($urandom_range(0, 15));
            stall = model_stall(q1, q2, qd);
            iv = !stall && ($urandom_range(0, 1) == 1) && !m_busy[ia];
            drive(($urandom_range(0, 2) != 0), 4'($urandom_range(0, 15)), 16'($urandom),
                  ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 16'($urandom),
                  iv, ia, q1, q2, qd);
            #1;
            ga = model_grant_a(bus.a_valid, bus.b_valid);
            f1 = BYP && m_we && (m_wa == q1) && (q1 != 0);
            f2 = BYP && m_we && (m_wa == q2) && (q2 != 0);
            chk("rand a_ready",  32'(bus.a_ready),  32'(ga));
            chk("rand b_ready",  32'(bus.b_ready),  32'(bus.b_valid && !ga));
            chk("rand we",       32'(bus.we),       32'(m_we));
            chk("rand w_addr",   32'(bus.w_addr),   32'(m_wa));
            chk("rand w_data",   32'(bus.w_data),   32'(m_wd));
            chk("rand busy",     32'(bus.busy),     32'(model_busy_vec()));
            chk("rand q_stall",  32'(bus.q_stall),  32'(stall));
            chk("rand fwd1",     32'(bus.fwd1_hit), 32'(f1));
            chk("rand fwd2",     32'(bus.fwd2_hit), 32'(f2));
            chk("rand fwd_data", 32'(bus.fwd_data), BYP ? 32'(m_wd) : 32'd0);
            @(posedge clock);
            model_step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
